// File: rtl/emmc_card_cmd_resp_if.sv
// Card-side CMD line plus the transfer-command hand-off towards the card data engine.
// The slave modport is the card responder; the master modport is the host/bench side.
interface emmc_card_cmd_resp_if;
  logic        emmc_cmd_i;
  logic        emmc_cmd_o;
  logic        emmc_cmd_oe_o;
  logic        cmd_valid_o;
  logic [5:0]  cmd_idx_o;
  logic [31:0] cmd_arg_o;
  logic        crc_err_o;

  modport slave (
    input  emmc_cmd_i,
    output emmc_cmd_o,
    output emmc_cmd_oe_o,
    output cmd_valid_o,
    output cmd_idx_o,
    output cmd_arg_o,
    output crc_err_o
  );

  modport master (
    output emmc_cmd_i,
    input  emmc_cmd_o,
    input  emmc_cmd_oe_o,
    input  cmd_valid_o,
    input  cmd_idx_o,
    input  cmd_arg_o,
    input  crc_err_o
  );
endinterface

// File: rtl/emmc_card_cmd_resp.sv
// eMMC card-side CMD responder: receives 48-bit host commands, checks CRC7/framing,
// tracks the identification/transfer card state and answers with R1/R2/R3 frames.
//
// line state  | meaning
// RX_IDLE     | waiting for a start bit on the CMD line
// RX_SHIFT    | capturing the remaining 47 command bits
// DECODE      | one cycle: check frame, update card state, pick response
// WAIT_NCR    | line released for the N_CR turnaround gap
// TX_SHIFT    | driving the response frame MSB first
module emmc_card_cmd_resp #(
  parameter int unsigned N_CR        = 2,
  parameter logic [15:0] RCA_DEFAULT = 16'h0001
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  emmc_card_cmd_resp_if.slave  bus,
  input  logic [31:0]          ocr_i,
  input  logic [127:0]         cid_i,
  input  logic [127:0]         csd_i,
  input  logic                 card_busy_i,
  input  logic                 ready_for_data_i,
  output logic [15:0]          rca_o,
  output logic [3:0]           state_o
);

  typedef enum logic [2:0] {
    LN_RX_IDLE,
    LN_RX_SHIFT,
    LN_DECODE,
    LN_WAIT_NCR,
    LN_TX_SHIFT
  } line_e;

  typedef enum logic [3:0] {
    CS_IDLE  = 4'd0,
    CS_READY = 4'd1,
    CS_IDENT = 4'd2,
    CS_STBY  = 4'd3,
    CS_TRAN  = 4'd4
  } card_e;

  typedef enum logic [2:0] {
    RESP_NONE,
    RESP_R1,
    RESP_R2_CID,
    RESP_R2_CSD,
    RESP_R3
  } resp_e;

  localparam logic [6:0] NCR_LOAD   = 7'(N_CR - 2);
  localparam logic [7:0] RX_BITS_M1 = 8'd46;
  localparam logic [7:0] R48_M1     = 8'd47;
  localparam logic [7:0] R136_M1    = 8'd135;

  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0] c;
    logic       fb;
    c = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  line_e         line_q, line_d;
  card_e         card_q, card_d;
  logic [46:0]   rx_sr_q, rx_sr_d;
  logic [135:0]  tx_sr_q, tx_sr_d;
  logic [7:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    ncr_cnt_q, ncr_cnt_d;
  logic [15:0]   rca_q, rca_d;
  logic [5:0]    cmd_idx_q, cmd_idx_d;
  logic [31:0]   cmd_arg_q, cmd_arg_d;
  logic          com_crc_err_q, com_crc_err_d;
  logic          illegal_q, illegal_d;

  logic          rx_trans, rx_end;
  logic [5:0]    rx_idx;
  logic [31:0]   rx_arg;
  logic [6:0]    rx_crc, rx_crc_calc;
  logic          frame_ok, rca_ok;
  logic [31:0]   status;
  logic [39:0]   r1_body;
  logic [6:0]    r1_crc;

  resp_e         dec_resp;
  card_e         dec_card;
  logic          dec_rca_load;
  logic          dec_illegal;
  logic          dec_xfer;
  logic [135:0]  dec_frame;
  logic [7:0]    dec_len_m1;

  logic          unused_bits;
  assign unused_bits = ^{ocr_i[31], cid_i[0], csd_i[0]};

  // Received frame fields; the start bit is not kept in the shift register.
  assign rx_trans    = rx_sr_q[46];
  assign rx_idx      = rx_sr_q[45:40];
  assign rx_arg      = rx_sr_q[39:8];
  assign rx_crc      = rx_sr_q[7:1];
  assign rx_end      = rx_sr_q[0];
  assign rx_crc_calc = crc7({1'b0, rx_sr_q[46:8]});
  assign frame_ok    = rx_trans && rx_end && (rx_crc == rx_crc_calc);
  assign rca_ok      = (rx_arg[31:16] == rca_q);

  assign status  = {8'h00, com_crc_err_q, illegal_q, 9'h000, card_q, ready_for_data_i, 8'h00};
  assign r1_body = {2'b00, rx_idx, status};
  assign r1_crc  = crc7(r1_body);

  // Command table
  always_comb begin
    dec_resp     = RESP_NONE;
    dec_card     = card_q;
    dec_rca_load = 1'b0;
    dec_illegal  = 1'b0;
    dec_xfer     = 1'b0;
    if (frame_ok) begin
      case (rx_idx)
        6'd0: begin
          dec_card     = CS_IDLE;
          dec_rca_load = 1'b1;
        end
        6'd1: begin
          if (card_q == CS_IDLE) begin
            dec_resp = RESP_R3;
            if (!card_busy_i) dec_card = CS_READY;
          end else begin
            dec_illegal = 1'b1;
          end
        end
        6'd2: begin
          if (card_q == CS_READY) begin
            dec_resp = RESP_R2_CID;
            dec_card = CS_IDENT;
          end else begin
            dec_illegal = 1'b1;
          end
        end
        6'd3: begin
          if (card_q == CS_IDENT) begin
            dec_resp     = RESP_R1;
            dec_rca_load = 1'b1;
            dec_card     = CS_STBY;
          end else begin
            dec_illegal = 1'b1;
          end
        end
        6'd9: begin
          if (card_q == CS_STBY || card_q == CS_TRAN) begin
            if (rca_ok) begin
              if (card_q == CS_STBY) dec_resp = RESP_R2_CSD;
              else                   dec_illegal = 1'b1;
            end
          end else begin
            dec_illegal = 1'b1;
          end
        end
        6'd7: begin
          if (card_q == CS_STBY) begin
            if (rca_ok) begin
              dec_resp = RESP_R1;
              dec_card = CS_TRAN;
            end
          end else if (card_q == CS_TRAN) begin
            if (!rca_ok) dec_card    = CS_STBY;
            else         dec_illegal = 1'b1;
          end else begin
            dec_illegal = 1'b1;
          end
        end
        6'd13: begin
          if (card_q == CS_STBY || card_q == CS_TRAN) begin
            if (rca_ok) dec_resp = RESP_R1;
          end else begin
            dec_illegal = 1'b1;
          end
        end
        6'd6, 6'd8, 6'd12, 6'd17, 6'd18, 6'd24, 6'd25: begin
          if (card_q == CS_TRAN) begin
            dec_resp = RESP_R1;
            dec_xfer = 1'b1;
          end else begin
            dec_illegal = 1'b1;
          end
        end
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  // Response frames are left-aligned in the 136-bit shifter.
  always_comb begin
    dec_frame  = '1;
    dec_len_m1 = R48_M1;
    case (dec_resp)
      RESP_R1:     dec_frame = {r1_body, r1_crc, 1'b1, 88'h0};
      RESP_R3:     dec_frame = {2'b00, 6'h3F, ~card_busy_i, ocr_i[30:0], 7'h7F, 1'b1, 88'h0};
      RESP_R2_CID: begin
        dec_frame  = {2'b00, 6'h3F, cid_i[127:1], 1'b1};
        dec_len_m1 = R136_M1;
      end
      RESP_R2_CSD: begin
        dec_frame  = {2'b00, 6'h3F, csd_i[127:1], 1'b1};
        dec_len_m1 = R136_M1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_q        <= LN_RX_IDLE;
      card_q        <= CS_IDLE;
      rx_sr_q       <= '0;
      tx_sr_q       <= '1;
      bit_cnt_q     <= '0;
      ncr_cnt_q     <= '0;
      rca_q         <= RCA_DEFAULT;
      cmd_idx_q     <= '0;
      cmd_arg_q     <= '0;
      com_crc_err_q <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      line_q        <= line_d;
      card_q        <= card_d;
      rx_sr_q       <= rx_sr_d;
      tx_sr_q       <= tx_sr_d;
      bit_cnt_q     <= bit_cnt_d;
      ncr_cnt_q     <= ncr_cnt_d;
      rca_q         <= rca_d;
      cmd_idx_q     <= cmd_idx_d;
      cmd_arg_q     <= cmd_arg_d;
      com_crc_err_q <= com_crc_err_d;
      illegal_q     <= illegal_d;
    end
  end

  always_comb begin
    line_d        = line_q;
    card_d        = card_q;
    rx_sr_d       = rx_sr_q;
    tx_sr_d       = tx_sr_q;
    bit_cnt_d     = bit_cnt_q;
    ncr_cnt_d     = ncr_cnt_q;
    rca_d         = rca_q;
    cmd_idx_d     = cmd_idx_q;
    cmd_arg_d     = cmd_arg_q;
    com_crc_err_d = com_crc_err_q;
    illegal_d     = illegal_q;
    case (line_q)
      LN_RX_IDLE: begin
        if (!bus.emmc_cmd_i) begin
          line_d    = LN_RX_SHIFT;
          bit_cnt_d = RX_BITS_M1;
        end
      end
      LN_RX_SHIFT: begin
        rx_sr_d = {rx_sr_q[45:0], bus.emmc_cmd_i};
        if (bit_cnt_q == 8'd0) line_d    = LN_DECODE;
        else                   bit_cnt_d = bit_cnt_q - 8'd1;
      end
      LN_DECODE: begin
        // Error bits clear when reported in an R1; a fresh error overrides the clear.
        if (dec_resp == RESP_R1) begin
          com_crc_err_d = 1'b0;
          illegal_d     = 1'b0;
        end
        if (!frame_ok) com_crc_err_d = 1'b1;
        if (dec_illegal) illegal_d = 1'b1;
        card_d = dec_card;
        if (dec_rca_load) rca_d = (rx_idx == 6'd0) ? RCA_DEFAULT : rx_arg[31:16];
        if (dec_xfer) begin
          cmd_idx_d = rx_idx;
          cmd_arg_d = rx_arg;
        end
        if (dec_resp != RESP_NONE) begin
          line_d    = LN_WAIT_NCR;
          ncr_cnt_d = NCR_LOAD;
          tx_sr_d   = dec_frame;
          bit_cnt_d = dec_len_m1;
        end else begin
          line_d = LN_RX_IDLE;
        end
      end
      LN_WAIT_NCR: begin
        if (ncr_cnt_q == 7'd0) line_d    = LN_TX_SHIFT;
        else                   ncr_cnt_d = ncr_cnt_q - 7'd1;
      end
      LN_TX_SHIFT: begin
        tx_sr_d = {tx_sr_q[134:0], 1'b1};
        if (bit_cnt_q == 8'd0) line_d    = LN_RX_IDLE;
        else                   bit_cnt_d = bit_cnt_q - 8'd1;
      end
      default: line_d = LN_RX_IDLE;
    endcase
  end

  always_comb begin
    bus.emmc_cmd_oe_o = (line_q == LN_TX_SHIFT);
    bus.emmc_cmd_o    = (line_q == LN_TX_SHIFT) ? tx_sr_q[135] : 1'b1;
    bus.crc_err_o     = (line_q == LN_DECODE) && !frame_ok;
    bus.cmd_valid_o   = (line_q == LN_DECODE) && dec_xfer;
    bus.cmd_idx_o     = cmd_idx_q;
    bus.cmd_arg_o     = cmd_arg_q;
    rca_o             = rca_q;
    state_o           = card_q;
  end

endmodule

// File: tb/tb_emmc_card_cmd_resp.sv
// Bench for emmc_card_cmd_resp: directed host commands, expected responses queued
// by the stimulus and checked bit-by-bit by an independent line monitor.
module tb_emmc_card_cmd_resp;
  localparam int N_CR = 3;

  typedef struct {
    int           len;
    logic [135:0] bits;
    int           start;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  ocr = 32'h80FF_8080;
  logic [127:0] cid = 128'h1501_0044_4D4D_4331_3620_1234_5678_AB01;
  logic [127:0] csd = 128'hD027_0132_0F59_03FF_F6DB_FFEF_8E40_402D;
  logic         busy = 1'b1;
  logic         rdy  = 1'b1;
  logic [15:0]  rca;
  logic [3:0]   st;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_starts = 0;
  int   crc_err_cnt = 0;
  int   valid_cnt = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  emmc_card_cmd_resp_if bus ();

  emmc_card_cmd_resp #(.N_CR(N_CR), .RCA_DEFAULT(16'h0001)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .bus              (bus),
    .ocr_i            (ocr),
    .cid_i            (cid),
    .csd_i            (csd),
    .card_busy_i      (busy),
    .ready_for_data_i (rdy),
    .rca_o            (rca),
    .state_o          (st)
  );

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  // Reference CRC7 as polynomial long division of msg*x^7 by x^7+x^3+1.
  function automatic logic [6:0] crc7_ref(input logic [39:0] msg);
    logic [46:0] m;
    m = {msg, 7'h00};
    for (int i = 46; i >= 7; i--)
      if (m[i]) m[i -: 8] = m[i -: 8] ^ 8'h89;
    return m[6:0];
  endfunction

  function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] b;
    b = {2'b01, idx, arg};
    return {b, crc7_ref(b), 1'b1};
  endfunction

  function automatic logic [135:0] r1_bits(input logic [5:0] idx, input logic [31:0] status);
    logic [39:0] b;
    b = {2'b00, idx, status};
    return {88'h0, b, crc7_ref(b), 1'b1};
  endfunction

  function automatic logic [135:0] r3_bits(input logic [31:0] o);
    return {88'h0, 2'b00, 6'h3F, o, 7'h7F, 1'b1};
  endfunction

  function automatic logic [135:0] r2_bits(input logic [127:0] r);
    return {2'b00, 6'h3F, r[127:1], 1'b1};
  endfunction

  // Drive one frame; queue the expected response as soon as the end bit is on the line.
  task automatic issue(input logic [47:0] f, input bit has_resp, input int len,
                       input logic [135:0] bits, input int wait_cyc);
    exp_t e;
    for (int i = 47; i >= 0; i--) begin
      @(negedge clk);
      bus.emmc_cmd_i = f[i];
    end
    if (has_resp) begin
      e.len   = len;
      e.bits  = bits;
      e.start = cyc + N_CR + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.emmc_cmd_i = 1'b1;
    repeat (wait_cyc) @(negedge clk);
  endtask

  task automatic cmd_none(input string name, input logic [47:0] f);
    int s0;
    s0 = n_starts;
    issue(f, 1'b0, 0, '0, 170);
    check(name, n_starts, s0);
  endtask

  task automatic cmd_r1(input logic [5:0] idx, input logic [31:0] arg, input logic [31:0] status);
    issue(mk_cmd(idx, arg), 1'b1, 48, r1_bits(idx, status), 170);
  endtask

  // Line monitor: every response start pops one expectation.
  initial begin : monitor
    exp_t         e;
    logic [135:0] got;
    bit           aborted;
    bit           held;
    forever begin
      @(negedge clk);
      if (bus.emmc_cmd_oe_o === 1'b1) begin
        n_starts++;
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 1, 0);
          for (int k = 0; k < 200 && bus.emmc_cmd_oe_o === 1'b1; k++) @(negedge clk);
        end else begin
          e = exp_q.pop_front();
          check("resp_start_cycle", cyc, e.start);
          got = '0;
          aborted = 1'b0;
          held = 1'b1;
          for (int i = 0; i < e.len; i++) begin
            if (i > 0) @(negedge clk);
            if (rst === 1'b1) begin
              aborted = 1'b1;
              break;
            end
            if (bus.emmc_cmd_oe_o !== 1'b1) held = 1'b0;
            got = {got[134:0], bus.emmc_cmd_o};
          end
          if (!aborted) begin
            check("resp_oe_held", held, 1'b1);
            check("resp_bits", got, e.bits);
            @(negedge clk);
            check("resp_release", {bus.emmc_cmd_oe_o, bus.emmc_cmd_o}, 2'b01);
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus.crc_err_o === 1'b1) crc_err_cnt++;
    if (bus.cmd_valid_o === 1'b1) valid_cnt++;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    logic [47:0] f;
    bus.emmc_cmd_i = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", st, 4'd0);
    check("rst_rca", rca, 16'h0001);
    check("rst_line", {bus.emmc_cmd_oe_o, bus.emmc_cmd_o}, 2'b01);
    check("rst_pulses", {bus.cmd_valid_o, bus.crc_err_o}, 2'b00);
    check("rst_idx_arg", {bus.cmd_idx_o, bus.cmd_arg_o}, 38'h0);

    // Power-up: busy card answers CMD1 with OCR[31]=0 and stays IDLE.
    cmd_none("no_resp_cmd0", mk_cmd(6'd0, 32'h0));
    issue(mk_cmd(6'd1, 32'h40FF8080), 1'b1, 48, r3_bits(32'h00FF8080), 170);
    check("busy_state", st, 4'd0);
    busy = 1'b0;
    issue(mk_cmd(6'd1, 32'h40FF8080), 1'b1, 48, r3_bits(32'h80FF8080), 170);
    check("ready_state", st, 4'd1);

    // Identification.
    issue(mk_cmd(6'd2, 32'h0), 1'b1, 136, r2_bits(cid), 170);
    check("ident_state", st, 4'd2);
    cmd_r1(6'd3, 32'h00040000, 32'h0000_0500);
    check("cmd3_rca", rca, 16'h0004);
    check("stby_state", st, 4'd3);

    // Corrupted argument bit, then error reporting and clearing.
    f = mk_cmd(6'd13, 32'h00040000);
    f[20] = ~f[20];
    cmd_none("no_resp_bad_crc", f);
    check("crc_err_pulse", crc_err_cnt, 1);
    check("bad_crc_state", st, 4'd3);
    cmd_r1(6'd13, 32'h00040000, 32'h0080_0700);
    cmd_r1(6'd13, 32'h00040000, 32'h0000_0700);

    // Select / transfer.
    cmd_none("no_resp_cmd7_badrca", mk_cmd(6'd7, 32'h00050000));
    check("cmd7_badrca_state", st, 4'd3);
    cmd_r1(6'd7, 32'h00040000, 32'h0000_0700);
    check("tran_state", st, 4'd4);
    cmd_r1(6'd17, 32'h00000010, 32'h0000_0900);
    check("cmd17_valid_pulse", valid_cnt, 1);
    check("cmd17_idx", bus.cmd_idx_o, 6'd17);
    check("cmd17_arg", bus.cmd_arg_o, 32'h10);

    // Illegal command and framing errors in TRAN.
    cmd_none("no_resp_cmd2_tran", mk_cmd(6'd2, 32'h0));
    cmd_r1(6'd13, 32'h00040000, 32'h0040_0900);
    f = mk_cmd(6'd13, 32'h00040000);
    f[0] = 1'b0;
    cmd_none("no_resp_end_bit", f);
    f = mk_cmd(6'd13, 32'h00040000);
    f[46] = 1'b0;
    cmd_none("no_resp_trans_bit", f);
    check("framing_err_pulses", crc_err_cnt, 3);
    cmd_r1(6'd13, 32'h00040000, 32'h0080_0900);
    check("tran_kept", st, 4'd4);

    // Deselect, then reset in the middle of a CSD response.
    cmd_none("no_resp_deselect", mk_cmd(6'd7, 32'h00090000));
    check("deselect_state", st, 4'd3);
    issue(mk_cmd(6'd9, 32'h00040000), 1'b1, 136, r2_bits(csd), 40);
    check("mid_r2_oe", bus.emmc_cmd_oe_o, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_line", {bus.emmc_cmd_oe_o, bus.emmc_cmd_o}, 2'b01);
    check("abort_state", st, 4'd0);
    check("abort_rca", rca, 16'h0001);
    check("abort_idx_arg", {bus.cmd_idx_o, bus.cmd_arg_o}, 38'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    issue(mk_cmd(6'd1, 32'h40FF8080), 1'b1, 48, r3_bits(32'h80FF8080), 170);
    check("post_rst_ready", st, 4'd1);

    // Re-identify with a new RCA and read CSD in full.
    issue(mk_cmd(6'd2, 32'h0), 1'b1, 136, r2_bits(cid), 170);
    cmd_r1(6'd3, 32'h00070000, 32'h0000_0500);
    check("rca_7", rca, 16'h0007);
    issue(mk_cmd(6'd9, 32'h00070000), 1'b1, 136, r2_bits(csd), 170);
    cmd_none("no_resp_cmd0_stby", mk_cmd(6'd0, 32'hFFFF_FFFF));
    check("cmd0_state", st, 4'd0);
    check("cmd0_rca", rca, 16'h0001);
    check("valid_total", valid_cnt, 1);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
